// File: rtl/rtc_reg_pkg.sv
// Shared constants for the RTC register sequencer: register indices,
// command address, FSM state encodings and the index-to-address map.
package rtc_reg_pkg;

  // Register indices as seen by the control FSM / data mux
  localparam int unsigned SEG    = 0;
  localparam int unsigned MIN    = 1;
  localparam int unsigned HORA   = 2;
  localparam int unsigned DIA    = 3;
  localparam int unsigned MES    = 4;
  localparam int unsigned ANIO   = 5;
  localparam int unsigned SEG_T  = 6;
  localparam int unsigned MIN_T  = 7;
  localparam int unsigned HORA_T = 8;
  localparam int unsigned CTRL   = 9;

  // Commit/command transfer address
  localparam logic [7:0] CMD_ADDR_DEF = 8'hF0;

  // Sequencer FSM state encodings
  localparam int unsigned ST_W    = 2;
  localparam logic [1:0]  ST_IDLE = 2'd0;
  localparam logic [1:0]  ST_REQ  = 2'd1;
  localparam logic [1:0]  ST_GAP  = 2'd2;
  localparam logic [1:0]  ST_CMT  = 2'd3;

  // Register index to RTC bus address; unmapped indices read as 0x00
  function automatic logic [7:0] reg_addr(input logic [7:0] idx);
    logic [7:0] addr;
    case (idx)
      8'(SEG):    addr = 8'h20;
      8'(MIN):    addr = 8'h21;
      8'(HORA):   addr = 8'h22;
      8'(DIA):    addr = 8'h23;
      8'(MES):    addr = 8'h24;
      8'(ANIO):   addr = 8'h25;
      8'(SEG_T):  addr = 8'h26;
      8'(MIN_T):  addr = 8'h41;
      8'(HORA_T): addr = 8'h42;
      8'(CTRL):   addr = 8'h43;
      default:    addr = 8'h00;
    endcase
    return addr;
  endfunction

endpackage

// File: rtl/rtc_reg_sequencer.sv
// Handshaked sweep engine: walks a register index range, issues one RTC bus
// transfer per register with a one-cycle gap between them, and optionally
// appends a command/commit write. All outputs are registered.
module rtc_reg_sequencer
  import rtc_reg_pkg::*;
#(
  parameter int unsigned          N_REGS   = 10,
  parameter int unsigned          ADDR_W   = 8,
  parameter logic [ADDR_W-1:0]    CMD_ADDR = ADDR_W'(CMD_ADDR_DEF),
  parameter int unsigned          TIMEOUT  = 255,
  // Derived from N_REGS; leave at default
  parameter int unsigned          IDX_W    = $clog2(N_REGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [IDX_W-1:0]  first_idx,
  input  logic [IDX_W-1:0]  last_idx,
  input  logic              wr,
  input  logic              commit,
  input  logic              bus_ack,
  output logic              bus_req,
  output logic [ADDR_W-1:0] bus_addr,
  output logic              bus_wr,
  output logic [IDX_W-1:0]  bus_idx,
  output logic              busy,
  output logic              done,
  output logic              err
);

  // Counter only has to reach TIMEOUT-1 before the transfer is abandoned
  localparam int unsigned    CNT_W    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam bit             TO_EN    = (TIMEOUT != 0);

  logic [1:0]        state_q,    state_d;
  logic [IDX_W-1:0]  idx_q,      idx_d;
  logic [IDX_W-1:0]  last_q,     last_d;
  logic              wr_q,       wr_d;
  logic              commit_q,   commit_d;
  logic [CNT_W-1:0]  cnt_q,      cnt_d;
  logic              bus_req_q,  bus_req_d;
  logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
  logic              bus_wr_q,   bus_wr_d;
  logic [IDX_W-1:0]  bus_idx_q,  bus_idx_d;
  logic              busy_q,     busy_d;
  logic              done_q,     done_d;
  logic              err_q,      err_d;
  logic              start_ok_c;

  // Range check for a new sweep request
  always_comb begin
    start_ok_c = (first_idx <= last_idx) && (32'(last_idx) < N_REGS);
  end

  // Next-state, sweep bookkeeping and registered-output decode
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    last_d     = last_q;
    wr_d       = wr_q;
    commit_d   = commit_q;
    cnt_d      = cnt_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    bus_req_d  = 1'b0;
    bus_addr_d = bus_addr_q;
    bus_wr_d   = bus_wr_q;
    bus_idx_d  = bus_idx_q;
    busy_d     = busy_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (start_ok_c) begin
            state_d  = ST_REQ;
            idx_d    = first_idx;
            last_d   = last_idx;
            wr_d     = wr;
            commit_d = commit;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_REQ: begin
        if (bus_ack) begin
          if (idx_q == last_q) begin
            if (commit_q) begin
              state_d = ST_CMT;
            end else begin
              state_d = ST_IDLE;
              done_d  = 1'b1;
            end
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = ST_GAP;
          end
        end else if (TO_EN && (cnt_q == CNT_LAST)) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
        end
      end
      ST_GAP: begin
        state_d = ST_REQ;
      end
      ST_CMT: begin
        if (bus_ack) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else if (TO_EN && (cnt_q == CNT_LAST)) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Wait counter restarts whenever a transfer is (re)entered
    if ((state_d == state_q) && ((state_q == ST_REQ) || (state_q == ST_CMT))) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = '0;
    end

    // Outputs follow the state being entered; address/dir/index hold otherwise
    busy_d = (state_d != ST_IDLE);
    case (state_d)
      ST_REQ: begin
        bus_req_d  = 1'b1;
        bus_addr_d = ADDR_W'(reg_addr(8'(idx_d)));
        bus_wr_d   = wr_d;
        bus_idx_d  = idx_d;
      end
      ST_CMT: begin
        bus_req_d  = 1'b1;
        bus_addr_d = CMD_ADDR;
        bus_wr_d   = 1'b1;
        bus_idx_d  = '0;
      end
      default: begin
        bus_req_d = 1'b0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      last_q     <= '0;
      wr_q       <= 1'b0;
      commit_q   <= 1'b0;
      cnt_q      <= '0;
      bus_req_q  <= 1'b0;
      bus_addr_q <= '0;
      bus_wr_q   <= 1'b0;
      bus_idx_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      last_q     <= last_d;
      wr_q       <= wr_d;
      commit_q   <= commit_d;
      cnt_q      <= cnt_d;
      bus_req_q  <= bus_req_d;
      bus_addr_q <= bus_addr_d;
      bus_wr_q   <= bus_wr_d;
      bus_idx_q  <= bus_idx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign bus_req  = bus_req_q;
  assign bus_addr = bus_addr_q;
  assign bus_wr   = bus_wr_q;
  assign bus_idx  = bus_idx_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule

// File: tb/tb_rtc_reg_sequencer.sv
// Scoreboard bench for rtc_reg_sequencer: expected transfers are queued when
// a sweep is launched and popped as the DUT raises each bus request.
module tb_rtc_reg_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_a = 1'b0;
  logic       start_b = 1'b0;
  logic       start;
  logic [3:0] first_idx = 4'd0;
  logic [3:0] last_idx = 4'd0;
  logic       wr = 1'b0;
  logic       commit = 1'b0;
  logic       bus_ack = 1'b0;
  logic       bus_req;
  logic [7:0] bus_addr;
  logic       bus_wr;
  logic [3:0] bus_idx;
  logic       busy;
  logic       done;
  logic       err;

  assign start = start_a | start_b;

  rtc_reg_sequencer #(.TIMEOUT(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .first_idx (first_idx),
    .last_idx  (last_idx),
    .wr        (wr),
    .commit    (commit),
    .bus_ack   (bus_ack),
    .bus_req   (bus_req),
    .bus_addr  (bus_addr),
    .bus_wr    (bus_wr),
    .bus_idx   (bus_idx),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] addr;
    logic       wr;
    logic [3:0] idx;
    int         gap;   // required low cycles before this request; -1 = don't care
  } xfer_t;

  xfer_t exp_q[$];
  int n_checks = 0;
  int n_errs   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] ref_addr(input int i);
    case (i)
      0: return 8'h20;
      1: return 8'h21;
      2: return 8'h22;
      3: return 8'h23;
      4: return 8'h24;
      5: return 8'h25;
      6: return 8'h26;
      7: return 8'h41;
      8: return 8'h42;
      9: return 8'h43;
      default: return 8'h00;
    endcase
  endfunction

  // Bus responder / monitor state
  bit auto_ack = 1'b1;
  bit noise_en = 1'b0;
  int ack_dly  = 2;
  bit req_prev = 1'b0;
  bit done_prev = 1'b0;
  bit err_prev = 1'b0;
  int xfer_cyc = 0;
  int low_cnt  = 0;
  int last_hi  = 0;
  int done_cnt = 0;
  int err_cnt  = 0;
  int snap_done = 0;
  int snap_err  = 0;

  // Monitor, scoreboard compare and bus responder, all sampled on negedge
  always @(negedge clk) begin : mon
    xfer_t x;
    if (bus_req && (!req_prev || bus_ack)) begin
      check_eq("xfer_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        check_eq("bus_addr", 32'(bus_addr), 32'(x.addr));
        check_eq("bus_wr",   32'(bus_wr),   32'(x.wr));
        check_eq("bus_idx",  32'(bus_idx),  32'(x.idx));
        if (x.gap >= 0) check_eq("gap_cycles", 32'(low_cnt), 32'(x.gap));
      end
      xfer_cyc = 0;
    end else if (bus_req) begin
      xfer_cyc++;
    end
    if (!bus_req && req_prev) last_hi = xfer_cyc + 1;
    low_cnt = bus_req ? 0 : low_cnt + 1;
    if (done) begin
      done_cnt++;
      check_eq("done_width", 32'(done_prev), 32'd0);
      check_eq("busy_at_done", 32'(busy), 32'd0);
      check_eq("req_at_done", 32'(bus_req), 32'd0);
    end
    if (err) begin
      err_cnt++;
      check_eq("err_width", 32'(err_prev), 32'd0);
      check_eq("req_at_err", 32'(bus_req), 32'd0);
    end
    bus_ack   = (auto_ack && bus_req && (xfer_cyc == ack_dly)) || (noise_en && !bus_req);
    start_b   = noise_en && bus_req && (xfer_cyc == 1);
    req_prev  = bus_req;
    done_prev = done;
    err_prev  = err;
  end

  // Launch a sweep, queue its expected transfers, then scramble the inputs
  task automatic kick(input int f, input int l, input bit w, input bit c);
    bit ok;
    ok = (f <= l) && (l < 10);
    if (ok) begin
      for (int i = f; i <= l; i++) begin
        exp_q.push_back('{addr: ref_addr(i), wr: w, idx: 4'(i), gap: (i == f) ? -1 : 1});
      end
      if (c) exp_q.push_back('{addr: 8'hF0, wr: 1'b1, idx: 4'd0, gap: 0});
    end
    snap_done = done_cnt;
    snap_err  = err_cnt;
    first_idx = 4'(f);
    last_idx  = 4'(l);
    wr        = w;
    commit    = c;
    start_a   = 1'b1;
    @(negedge clk);
    start_a   = 1'b0;
    first_idx = 4'd0;
    last_idx  = 4'd9;
    wr        = ~w;
    commit    = ~c;
    check_eq("busy_t1", 32'(busy), 32'(ok));
    check_eq("req_t1", 32'(bus_req), 32'(ok));
  endtask

  // Wait (bounded) for the sweep to end, then check its outcome
  task automatic finish(input int exp_done, input int exp_err, input int exp_left);
    int n;
    n = 0;
    while ((done_cnt == snap_done) && (err_cnt == snap_err) && (n < 400)) begin
      @(negedge clk);
      n++;
    end
    check_eq("end_within_bound", 32'(n < 400), 32'd1);
    repeat (3) @(negedge clk);
    check_eq("done_count", 32'(done_cnt - snap_done), 32'(exp_done));
    check_eq("err_count",  32'(err_cnt - snap_err),   32'(exp_err));
    check_eq("queue_left", 32'(exp_q.size()),         32'(exp_left));
    check_eq("busy_after", 32'(busy), 32'd0);
    check_eq("req_after",  32'(bus_req), 32'd0);
    exp_q.delete();
  endtask

  initial begin : stim
    int n;
    repeat (3) @(negedge clk);
    check_eq("rst_bus_req",  32'(bus_req),  32'd0);
    check_eq("rst_bus_addr", 32'(bus_addr), 32'd0);
    check_eq("rst_bus_wr",   32'(bus_wr),   32'd0);
    check_eq("rst_bus_idx",  32'(bus_idx),  32'd0);
    check_eq("rst_busy",     32'(busy),     32'd0);
    check_eq("rst_done",     32'(done),     32'd0);
    check_eq("rst_err",      32'(err),      32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Full read sweep
    ack_dly = 2;
    kick(0, 9, 1'b0, 1'b0);
    finish(1, 0, 0);

    // Write sweep with commit
    ack_dly = 1;
    kick(0, 2, 1'b1, 1'b1);
    finish(1, 0, 0);

    // Invalid ranges
    kick(5, 3, 1'b0, 1'b0);
    finish(0, 1, 0);
    kick(0, 10, 1'b1, 1'b0);
    finish(0, 1, 0);

    // Timeout, then recovery
    auto_ack = 1'b0;
    kick(0, 1, 1'b0, 1'b0);
    finish(0, 1, 1);
    check_eq("timeout_req_cycles", 32'(last_hi), 32'd4);
    auto_ack = 1'b1;
    ack_dly  = 0;
    kick(3, 4, 1'b1, 1'b0);
    finish(1, 0, 0);

    // Start while busy and stray acks in GAP/IDLE
    noise_en = 1'b1;
    ack_dly  = 2;
    kick(2, 5, 1'b0, 1'b1);
    finish(1, 0, 0);
    noise_en = 1'b0;
    repeat (2) @(negedge clk);

    // Asynchronous reset in the middle of a sweep
    ack_dly = 2;
    kick(0, 9, 1'b0, 1'b0);
    n = 0;
    while (!(bus_req && (bus_idx == 4'd3)) && (n < 200)) begin
      @(negedge clk);
      n++;
    end
    check_eq("reach_idx3", 32'(n < 200), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_bus_req",  32'(bus_req),  32'd0);
    check_eq("arst_bus_addr", 32'(bus_addr), 32'd0);
    check_eq("arst_bus_wr",   32'(bus_wr),   32'd0);
    check_eq("arst_bus_idx",  32'(bus_idx),  32'd0);
    check_eq("arst_busy",     32'(busy),     32'd0);
    check_eq("arst_done",     32'(done),     32'd0);
    check_eq("arst_err",      32'(err),      32'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    snap_done = done_cnt;
    snap_err  = err_cnt;
    repeat (10) @(negedge clk);
    check_eq("post_rst_done", 32'(done_cnt - snap_done), 32'd0);
    check_eq("post_rst_err",  32'(err_cnt - snap_err),   32'd0);
    check_eq("post_rst_busy", 32'(busy), 32'd0);

    // Fresh sweep after reset
    ack_dly = 0;
    kick(7, 9, 1'b0, 1'b0);
    finish(1, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
